// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The optional performance counters are enabled with HAZARD_PERF_EN.
package pipe_ctrl_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int PERF_CNT_W = 32;
  localparam int WAIT_CNT_W = 8;

  // Controller states, kept as plain constants for older tool flows.
  typedef logic [1:0] state_t;
  localparam state_t ST_RUN      = 2'd0;
  localparam state_t ST_MEM_WAIT = 2'd1;
  localparam state_t ST_ERROR    = 2'd2;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_bubble;
    logic pc_src;
    logic dmem_req;
    logic err;
  } ctrl_t;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter with enable and asynchronous active-low reset.
module pipe_perf_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int W = PERF_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  // Sticks at all-ones instead of wrapping so long runs never look small.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hold/flush controller with data-memory handshake and timeout watchdog.
// Define HAZARD_PERF_EN to build the stall/flush/load-use performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int REG_AW      = REG_AW_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_AW-1:0]     id_rs1,
  input  logic [REG_AW-1:0]     id_rs2,
  input  logic                  id_ex_MemRead,
  input  logic [REG_AW-1:0]     id_ex_rd,
  input  logic                  ex_mem_Branch,
  input  logic                  ex_mem_zero,
  input  logic                  ex_mem_MemRead,
  input  logic                  ex_mem_MemWrite,
  input  logic                  dmem_ready,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_write,
  output logic                  ex_mem_write,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  mem_wb_bubble,
  output logic                  pc_src,
  output logic                  dmem_req,
  output logic                  err,
  output logic [PERF_CNT_W-1:0] perf_stall,
  output logic [PERF_CNT_W-1:0] perf_flush,
  output logic [PERF_CNT_W-1:0] perf_loaduse
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_M1 = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_q, wait_d;
  ctrl_t                 ctrl, ctrl_gated;

  logic memop, br_taken, load_use;
  logic mem_stall, br_act, lu_act, in_error;

  assign memop    = ex_mem_MemRead | ex_mem_MemWrite;
  assign br_taken = ex_mem_Branch & ex_mem_zero;
  assign load_use = id_ex_MemRead && (id_ex_rd != '0) &&
                    ((id_ex_rd == id_rs1) || (id_ex_rd == id_rs2));

  // The ready cycle of a wait falls back to the RUN equations, so the
  // completing access advances the pipeline in the same cycle.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_stall = 1'b0;
    in_error  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (memop && !dmem_ready) begin
          mem_stall = 1'b1;
          state_d   = ST_MEM_WAIT;
          wait_d    = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else begin
          mem_stall = 1'b1;
          if (wait_q == TIMEOUT_M1) begin
            state_d = ST_ERROR;
          end else begin
            wait_d = wait_q + WAIT_CNT_W'(1);
          end
        end
      end
      default: begin
        in_error = 1'b1;
        state_d  = ST_ERROR;
      end
    endcase
  end

  // A memory op in MEM outranks a branch there; load-use only acts when
  // nothing above it does, so a pending one reappears once a stall releases.
  assign br_act = !in_error && !mem_stall && !memop && br_taken;
  assign lu_act = !in_error && !mem_stall && !br_act && load_use;

  always_comb begin
    ctrl = '0;
    if (in_error) begin
      ctrl.err = 1'b1;
    end else if (mem_stall) begin
      ctrl.mem_wb_bubble = 1'b1;
      ctrl.dmem_req      = 1'b1;
    end else begin
      ctrl.pc_write     = 1'b1;
      ctrl.if_id_write  = 1'b1;
      ctrl.id_ex_write  = 1'b1;
      ctrl.ex_mem_write = 1'b1;
      ctrl.dmem_req     = memop;
      if (br_act) begin
        ctrl.pc_src       = 1'b1;
        ctrl.if_id_flush  = 1'b1;
        ctrl.id_ex_flush  = 1'b1;
        ctrl.ex_mem_flush = 1'b1;
      end else if (lu_act) begin
        ctrl.pc_write    = 1'b0;
        ctrl.if_id_write = 1'b0;
        ctrl.id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Reset forces every control low at once, even mid-wait.
  assign ctrl_gated = rst_n ? ctrl : '0;

  assign pc_write      = ctrl_gated.pc_write;
  assign if_id_write   = ctrl_gated.if_id_write;
  assign id_ex_write   = ctrl_gated.id_ex_write;
  assign ex_mem_write  = ctrl_gated.ex_mem_write;
  assign if_id_flush   = ctrl_gated.if_id_flush;
  assign id_ex_flush   = ctrl_gated.id_ex_flush;
  assign ex_mem_flush  = ctrl_gated.ex_mem_flush;
  assign mem_wb_bubble = ctrl_gated.mem_wb_bubble;
  assign pc_src        = ctrl_gated.pc_src;
  assign dmem_req      = ctrl_gated.dmem_req;
  assign err           = ctrl_gated.err;

`ifdef HAZARD_PERF_EN
  pipe_perf_cnt #(.W(PERF_CNT_W)) u_perf_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mem_stall | lu_act),
    .count (perf_stall)
  );

  pipe_perf_cnt #(.W(PERF_CNT_W)) u_perf_flush (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (br_act),
    .count (perf_flush)
  );

  pipe_perf_cnt #(.W(PERF_CNT_W)) u_perf_loaduse (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (lu_act),
    .count (perf_loaduse)
  );
`else
  assign perf_stall   = '0;
  assign perf_flush   = '0;
  assign perf_loaduse = '0;
`endif

endmodule
